// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mips_mem_pkg;
  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    D_BUSY,
    I_BUSY
  } state_t;

  localparam logic SRC_IF  = 1'b0;
  localparam logic SRC_MEM = 1'b1;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory request; flags the abort limit.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: MEM stage has priority over IF, one transaction
// in flight, pipeline stall, IF flush discard and request timeout.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall,
  output logic          bus_err,
  output logic          bus_err_src,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);
  state_t        r_state, w_next_state;
  logic          r_mem_req, r_mem_we, r_discard;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata, r_if_rdata, r_d_rdata;
  logic          r_if_ready, r_d_ready, r_bus_err, r_bus_err_src;
  logic          w_grant_d, w_grant_i, w_grant, w_busy, w_expired, w_timeout;

  assign w_busy    = (r_state != IDLE);
  assign w_grant   = w_grant_d | w_grant_i;
  assign w_timeout = w_busy & ~mem_ack & w_expired;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_grant),
    .i_en      (w_busy & ~mem_ack),
    .o_expired (w_expired)
  );

  // A requester whose ready is pulsing still holds req for the retiring
  // instruction, so it is held off for that one cycle.
  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req && !r_d_ready) begin
          w_grant_d    = 1'b1;
          w_next_state = D_BUSY;
        end else if (if_req && !r_if_ready && !if_flush) begin
          w_grant_i    = 1'b1;
          w_next_state = I_BUSY;
        end
      end
      D_BUSY, I_BUSY: begin
        if (mem_ack || w_expired) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_if_ready    <= 1'b0;
      r_d_ready     <= 1'b0;
      r_bus_err     <= 1'b0;
      r_bus_err_src <= SRC_IF;
      r_discard     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_bus_err  <= 1'b0;
      if (w_grant_d) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= d_we;
        r_mem_addr  <= d_addr;
        r_mem_wdata <= d_wdata;
      end else if (w_grant_i) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
      end
      // Ack on the limit edge completes normally rather than aborting.
      if (w_busy && mem_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == D_BUSY) begin
          r_d_ready <= 1'b1;
          if (!r_mem_we) r_d_rdata <= mem_rdata;
        end else if (!(r_discard || if_flush)) begin
          r_if_ready <= 1'b1;
          r_if_rdata <= mem_rdata;
        end
      end else if (w_timeout) begin
        r_mem_req     <= 1'b0;
        r_bus_err     <= 1'b1;
        r_bus_err_src <= (r_state == D_BUSY) ? SRC_MEM : SRC_IF;
      end
      if (w_next_state == IDLE) r_discard <= 1'b0;
      else if (r_state == I_BUSY && if_flush) r_discard <= 1'b1;
    end
  end

  assign stall       = (d_req & ~r_d_ready) | (if_req & ~r_if_ready & ~if_flush);
  assign if_rdata    = r_if_rdata;
  assign if_ready    = r_if_ready;
  assign d_rdata     = r_d_rdata;
  assign d_ready     = r_d_ready;
  assign bus_err     = r_bus_err;
  assign bus_err_src = r_bus_err_src;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-data scoreboard on the ready pulses.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, if_req, if_flush, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, stall, bus_err, bus_err_src, mem_req, mem_we;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] q_if[$];
  logic [31:0] q_d[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall(stall), .bus_err(bus_err), .bus_err_src(bus_err_src),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ready pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_ready", {31'b0, if_ready & d_ready}, 32'd0);
      if (if_ready) begin
        if (q_if.size() == 0) chk("if_ready_unexpected", {31'b0, if_ready}, 32'd0);
        else chk("if_rdata_sb", if_rdata, q_if.pop_front());
      end
      if (d_ready) begin
        if (q_d.size() == 0) chk("d_ready_unexpected", {31'b0, d_ready}, 32'd0);
        else chk("d_rdata_sb", d_rdata, q_d.pop_front());
      end
    end
  end

  initial begin
    rst_n = 0; if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_readies", {30'b0, if_ready, d_ready}, 0);
    chk("rst_bus_err", {30'b0, bus_err, bus_err_src}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    rst_n = 1;
    tick();

    // Lone fetch, ack in the first mem_req cycle
    if_req = 1; if_addr = 32'h0040_0000; q_if.push_back(32'h8C08_0004);
    #1 chk("fetch_stall_req", {31'b0, stall}, 1);
    tick();
    chk("fetch_mem_req", {31'b0, mem_req}, 1);
    chk("fetch_mem_addr", mem_addr, 32'h0040_0000);
    chk("fetch_mem_we", {31'b0, mem_we}, 0);
    chk("fetch_stall_busy", {31'b0, stall}, 1);
    mem_ack = 1; mem_rdata = 32'h8C08_0004;
    tick();
    chk("fetch_ready", {31'b0, if_ready}, 1);
    chk("fetch_req_clr", {31'b0, mem_req}, 0);
    chk("fetch_stall_ready", {31'b0, stall}, 0);
    mem_ack = 0; mem_rdata = '0;
    tick();
    chk("fetch_holdoff", {31'b0, mem_req}, 0);
    chk("fetch_ready_pulse", {31'b0, if_ready}, 0);
    if_req = 0;
    tick();

    // Contention: store wins, then the fetch in the d_ready cycle
    d_req = 1; d_we = 1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h0040_0004;
    q_d.push_back(32'h0); q_if.push_back(32'h1234_5678);
    tick();
    chk("cont_d_grant_we", {31'b0, mem_we}, 1);
    chk("cont_d_addr", mem_addr, 32'h1001_0000);
    chk("cont_d_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("cont_d_ready", {31'b0, d_ready}, 1);
    chk("cont_store_rdata", d_rdata, 32'h0);
    chk("cont_stall_if", {31'b0, stall}, 1);
    mem_ack = 0;
    tick();
    d_req = 0; d_we = 0;
    chk("cont_i_grant", {31'b0, mem_req}, 1);
    chk("cont_i_addr", mem_addr, 32'h0040_0004);
    chk("cont_i_we", {31'b0, mem_we}, 0);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick();
    chk("cont_if_ready", {31'b0, if_ready}, 1);
    mem_ack = 0; if_req = 0;
    tick();

    // Flush during fetch, ack on the third outstanding cycle
    if_req = 1; if_addr = 32'h0040_0008;
    tick();
    chk("flush_grant", {31'b0, mem_req}, 1);
    if_flush = 1;
    #1 chk("flush_stall", {31'b0, stall}, 0);
    tick();
    if_flush = 0; if_req = 0;
    chk("flush_req_held", {31'b0, mem_req}, 1);
    tick();
    mem_ack = 1; mem_rdata = 32'hBADB_AD00;
    tick();
    mem_ack = 0;
    chk("flush_req_clr", {31'b0, mem_req}, 0);
    chk("flush_no_ready", {31'b0, if_ready}, 0);
    chk("flush_rdata_kept", if_rdata, 32'h1234_5678);
    tick();
    chk("flush_idle", {31'b0, mem_req}, 0);

    // Timeout: lw never acked, TIMEOUT=4
    d_req = 1; d_we = 0; d_addr = 32'h1001_0010;
    tick();
    chk("tmo_grant", {31'b0, mem_req}, 1);
    tick(); tick(); tick();
    chk("tmo_req_c4", {31'b0, mem_req}, 1);
    tick();
    chk("tmo_req_drop", {31'b0, mem_req}, 0);
    chk("tmo_bus_err", {31'b0, bus_err}, 1);
    chk("tmo_src", {31'b0, bus_err_src}, 1);
    chk("tmo_stall", {31'b0, stall}, 1);
    d_req = 0;
    tick();
    chk("tmo_err_pulse", {31'b0, bus_err}, 0);
    chk("tmo_no_regrant", {31'b0, mem_req}, 0);

    // Ack on the limit edge wins over the timeout
    d_req = 1; d_addr = 32'h0000_0020; q_d.push_back(32'hCAFE_F00D);
    tick(); tick(); tick(); tick();
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 0;
    chk("lim_d_ready", {31'b0, d_ready}, 1);
    chk("lim_no_err", {31'b0, bus_err}, 0);
    tick();
    d_req = 0;
    tick();

    // Reset mid-transaction; late ack ignored
    d_req = 1; d_addr = 32'h0000_0030;
    tick();
    chk("rmid_grant", {31'b0, mem_req}, 1);
    rst_n = 0;
    tick();
    chk("rmid_mem_req", {31'b0, mem_req}, 0);
    chk("rmid_d_rdata", d_rdata, 0);
    chk("rmid_if_rdata", if_rdata, 0);
    chk("rmid_flags", {28'b0, if_ready, d_ready, bus_err, bus_err_src}, 0);
    rst_n = 1; d_req = 0; mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 0;
    tick();
    chk("rmid_late_ack", {31'b0, d_ready}, 0);

    // Back-to-back loads with held d_req
    d_req = 1; d_addr = 32'h0000_0010; q_d.push_back(32'h1111_1111);
    tick();
    chk("b2b_addr0", mem_addr, 32'h0000_0010);
    mem_ack = 1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 0;
    chk("b2b_ready0", {31'b0, d_ready}, 1);
    q_d.push_back(32'h2222_2222);
    tick();
    chk("b2b_holdoff", {31'b0, mem_req}, 0);
    d_addr = 32'h0000_0014;
    tick();
    chk("b2b_regrant", {31'b0, mem_req}, 1);
    chk("b2b_addr1", mem_addr, 32'h0000_0014);
    mem_ack = 1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 0;
    chk("b2b_ready1", {31'b0, d_ready}, 1);
    d_req = 0;
    tick(); tick();

    chk("if_queue_empty", 32'(q_if.size()), 0);
    chk("d_queue_empty", 32'(q_d.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
